// File: rtl/step_pkg.sv
// Shared types and constants for the two-axis stepper tracker.
package step_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } axis_state_e;

  localparam int   POS_W = 16;
  localparam logic POS   = 1'b1;
  localparam logic NEG   = 1'b0;

endpackage

// File: rtl/step_axis.sv
// One stepper axis: paces step/dir pulses from level commands and keeps a dead-reckoned position.
module step_axis
  import step_pkg::*;
#(
  parameter int STEP_DIV  = 50000,
  parameter int STEP_HIGH = 10,
  parameter int DIR_SETUP = 5,
  parameter int MODULUS   = 360,
  parameter bit WRAP_EN   = 1'b1,
  parameter int RESET_POS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_pos,
  input  logic             i_cmd_neg,
  output logic             o_step,
  output logic             o_dir,
  output logic [POS_W-1:0] o_pos,
  output axis_state_e      o_state
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0]    C_HIGH_LAST  = CW'(STEP_HIGH - 1);
  localparam logic [CW-1:0]    C_SETUP_LAST = CW'(DIR_SETUP - 1);
  localparam logic [CW-1:0]    C_DIV_LAST   = CW'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] C_MOD_LAST   = POS_W'(MODULUS - 1);
  localparam logic [POS_W-1:0] C_RESET_POS  = POS_W'(RESET_POS);

  axis_state_e      r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_step;
  logic             r_dir;
  logic [POS_W-1:0] r_pos;

  axis_state_e      w_state_nx;
  logic [CW-1:0]    w_cnt_nx;
  logic             w_dir_nx;
  logic [POS_W-1:0] w_pos_nx;
  logic             w_pos_only;
  logic             w_neg_only;
  logic             w_req_same;
  logic             w_req_flip;

  always_comb begin
    w_pos_only = i_cmd_pos & ~i_cmd_neg;
    w_neg_only = i_cmd_neg & ~i_cmd_pos;
    w_req_same = (r_dir == POS) ? w_pos_only : w_neg_only;
    w_req_flip = (r_dir == POS) ? w_neg_only : w_pos_only;
  end

  // The counter runs across PULSE and GAP so the step period is exactly STEP_DIV.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 1'b1;
    w_dir_nx   = r_dir;
    case (r_state)
      IDLE: begin
        w_cnt_nx = '0;
        if (w_req_same) begin
          w_state_nx = PULSE;
        end else if (w_req_flip) begin
          w_state_nx = SETUP;
          w_dir_nx   = ~r_dir;
        end
      end
      SETUP: begin
        if (r_cnt == C_SETUP_LAST) begin
          w_cnt_nx   = '0;
          w_state_nx = w_req_same ? PULSE : IDLE;
        end
      end
      PULSE: begin
        if (r_cnt == C_HIGH_LAST) w_state_nx = GAP;
      end
      GAP: begin
        if (r_cnt == C_DIV_LAST) begin
          w_cnt_nx   = '0;
          w_state_nx = w_req_same ? PULSE : IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Position moves once per pulse, on the cycle the step rises; pos decrements.
  always_comb begin
    w_pos_nx = r_pos;
    if (w_state_nx == PULSE && r_state != PULSE) begin
      if (r_dir == POS) begin
        if (WRAP_EN && r_pos == '0) w_pos_nx = C_MOD_LAST;
        else                        w_pos_nx = r_pos - 1'b1;
      end else begin
        if (WRAP_EN && r_pos == C_MOD_LAST) w_pos_nx = '0;
        else                                w_pos_nx = r_pos + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_step  <= 1'b0;
      r_dir   <= NEG;
      r_pos   <= C_RESET_POS;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_step  <= (w_state_nx == PULSE);
      r_dir   <= w_dir_nx;
      r_pos   <= w_pos_nx;
    end
  end

  assign o_step  = r_step;
  assign o_dir   = r_dir;
  assign o_pos   = r_pos;
  assign o_state = r_state;

endmodule

// File: rtl/motor_step_tracker.sv
// Two-axis step/dir generator with position feedback, conflict flag and busy.
// Optional theta soft limits when THETA_SOFT_LIMIT_EN is defined (adds theta_at_limit).
module motor_step_tracker
  import step_pkg::*;
#(
  parameter int STEP_DIV   = 50000,
  parameter int STEP_HIGH  = 10,
  parameter int DIR_SETUP  = 5,
  parameter int PHI_MAX    = 360,
  parameter int THETA_MIN  = 0,
  parameter int THETA_MAX  = 180,
  parameter int THETA_HOME = 90
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_theta_pos,
  input  logic             cmd_theta_neg,
  input  logic             cmd_phi_pos,
  input  logic             cmd_phi_neg,
  output logic             step_theta,
  output logic             step_phi,
  output logic             dir_theta,
  output logic             dir_phi,
  output logic [POS_W-1:0] theta_actual,
  output logic [POS_W-1:0] phi_actual,
  output logic             busy,
`ifdef THETA_SOFT_LIMIT_EN
  output logic             theta_at_limit,
`endif
  output logic             conflict
);

`ifdef THETA_SOFT_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam logic [POS_W-1:0] C_THETA_MIN = POS_W'(THETA_MIN);
  localparam logic [POS_W-1:0] C_THETA_MAX = POS_W'(THETA_MAX);

  axis_state_e w_theta_state;
  axis_state_e w_phi_state;
  logic        w_theta_pos_blk;
  logic        w_theta_neg_blk;
  logic        w_theta_cmd_pos;
  logic        w_theta_cmd_neg;
  logic        r_conflict;

  // A pos step decrements theta, so pos is blocked at the minimum and neg at the maximum.
  always_comb begin
    w_theta_pos_blk = cmd_theta_pos & ~cmd_theta_neg & (theta_actual <= C_THETA_MIN);
    w_theta_neg_blk = cmd_theta_neg & ~cmd_theta_pos & (theta_actual >= C_THETA_MAX);
    w_theta_cmd_pos = cmd_theta_pos & ~(LIMIT_EN & w_theta_pos_blk);
    w_theta_cmd_neg = cmd_theta_neg & ~(LIMIT_EN & w_theta_neg_blk);
  end

  step_axis #(
    .STEP_DIV (STEP_DIV),
    .STEP_HIGH(STEP_HIGH),
    .DIR_SETUP(DIR_SETUP),
    .MODULUS  (65536),
    .WRAP_EN  (1'b0),
    .RESET_POS(THETA_HOME)
  ) u_theta (
    .clk      (clk),
    .rst      (rst),
    .i_cmd_pos(w_theta_cmd_pos),
    .i_cmd_neg(w_theta_cmd_neg),
    .o_step   (step_theta),
    .o_dir    (dir_theta),
    .o_pos    (theta_actual),
    .o_state  (w_theta_state)
  );

  step_axis #(
    .STEP_DIV (STEP_DIV),
    .STEP_HIGH(STEP_HIGH),
    .DIR_SETUP(DIR_SETUP),
    .MODULUS  (PHI_MAX),
    .WRAP_EN  (1'b1),
    .RESET_POS(0)
  ) u_phi (
    .clk      (clk),
    .rst      (rst),
    .i_cmd_pos(cmd_phi_pos),
    .i_cmd_neg(cmd_phi_neg),
    .o_step   (step_phi),
    .o_dir    (dir_phi),
    .o_pos    (phi_actual),
    .o_state  (w_phi_state)
  );

  always_ff @(posedge clk) begin
    if (rst) r_conflict <= 1'b0;
    else     r_conflict <= (cmd_theta_pos & cmd_theta_neg) | (cmd_phi_pos & cmd_phi_neg);
  end

`ifdef THETA_SOFT_LIMIT_EN
  logic r_at_limit;
  always_ff @(posedge clk) begin
    if (rst) r_at_limit <= 1'b0;
    else     r_at_limit <= w_theta_pos_blk | w_theta_neg_blk;
  end
  assign theta_at_limit = r_at_limit;
`endif

  assign conflict = r_conflict;
  assign busy     = (w_theta_state != IDLE) | (w_phi_state != IDLE);

endmodule
